phys_reg_free_list: RTL

//  Free pool of physical registers for rename. Takes retire-side frees (phys reg released when
//  the R-RAT is updated at commit) and hands free registers to the rename/dispatch stage that

---
 rtl/phys_reg_free_list_if.sv | 37 +++
 rtl/phys_reg_free_list.sv | 101 ++++++++++
 2 files changed

// File: rtl/phys_reg_free_list_if.sv
// rtl/phys_reg_free_list_if.sv - rename-side allocate / commit-side free bundle for the physical register free list
interface phys_reg_free_list_if #(
    parameter int NUM_PHYS_REGS = 64
);
    localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);

    logic                Alloc_req_IN;
    logic                Alloc_grant_OUT;
    logic [LOG_PHYS-1:0] Alloc_reg_OUT;
    logic                Free_valid_IN;
    logic [LOG_PHYS-1:0] Free_reg_IN;
    logic                Empty_OUT;
    logic [LOG_PHYS:0]   Count_OUT;
    logic                Error_OUT;

    modport master (
        output Alloc_req_IN,
        output Free_valid_IN,
        output Free_reg_IN,
        input  Alloc_grant_OUT,
        input  Alloc_reg_OUT,
        input  Empty_OUT,
        input  Count_OUT,
        input  Error_OUT
    );

    modport slave (
        input  Alloc_req_IN,
        input  Free_valid_IN,
        input  Free_reg_IN,
        output Alloc_grant_OUT,
        output Alloc_reg_OUT,
        output Empty_OUT,
        output Count_OUT,
        output Error_OUT
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - circular FIFO of free physical register indices with double-free detection
module phys_reg_free_list #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_ARCH_REGS = 35
) (
    input  logic                  CLK,
    input  logic                  RESET,
    phys_reg_free_list_if.slave   fl
);
    localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);
    localparam int INIT_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam logic [LOG_PHYS:0] FULL_COUNT = (LOG_PHYS+1)'(NUM_PHYS_REGS);

    logic [LOG_PHYS-1:0]      mem [NUM_PHYS_REGS];
    logic [LOG_PHYS-1:0]      head;
    logic [LOG_PHYS-1:0]      tail;
    logic [LOG_PHYS:0]        count;
    logic [NUM_PHYS_REGS-1:0] free_map;
    logic                     err;

    logic                     empty;
    logic                     grant;
    logic                     in_range;
    logic                     has_room;
    logic                     free_legal;
    logic                     free_illegal;
    logic [NUM_PHYS_REGS-1:0] map_after_alloc;
    logic [NUM_PHYS_REGS-1:0] map_next;
    logic [LOG_PHYS:0]        count_next;
    logic [LOG_PHYS-1:0]      head_next;
    logic [LOG_PHYS-1:0]      tail_next;

    assign empty = (count == '0);
    assign grant = fl.Alloc_req_IN & ~empty;

    assign fl.Alloc_grant_OUT = grant;
    assign fl.Alloc_reg_OUT   = mem[head];
    assign fl.Empty_OUT       = empty;
    assign fl.Count_OUT       = count;
    assign fl.Error_OUT       = err;

    assign head_next = (head == LOG_PHYS'(NUM_PHYS_REGS - 1)) ? '0 : head + 1'b1;
    assign tail_next = (tail == LOG_PHYS'(NUM_PHYS_REGS - 1)) ? '0 : tail + 1'b1;

    // The allocation is applied to the bitmap before the free is judged, so a register
    // granted this cycle may legally come straight back, and a full list with a
    // simultaneous grant has a slot for the incoming free.
    always_comb begin
        map_after_alloc = free_map;
        if (grant) begin
            map_after_alloc[mem[head]] = 1'b0;
        end
        in_range     = ({1'b0, fl.Free_reg_IN} < FULL_COUNT);
        has_room     = grant || (count < FULL_COUNT);
        free_legal   = fl.Free_valid_IN && in_range && has_room
                       && !map_after_alloc[fl.Free_reg_IN];
        free_illegal = fl.Free_valid_IN && !free_legal;

        map_next = map_after_alloc;
        if (free_legal) begin
            map_next[fl.Free_reg_IN] = 1'b1;
        end

        count_next = count;
        case ({free_legal, grant})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_PHYS_REGS; i++) begin
                mem[i]      <= (i < INIT_FREE) ? LOG_PHYS'(NUM_ARCH_REGS + i) : '0;
                free_map[i] <= (i >= NUM_ARCH_REGS);
            end
            head  <= '0;
            tail  <= LOG_PHYS'(INIT_FREE);
            count <= (LOG_PHYS+1)'(INIT_FREE);
            err   <= 1'b0;
        end else begin
            if (grant) begin
                head <= head_next;
            end
            if (free_legal) begin
                mem[tail] <= fl.Free_reg_IN;
                tail      <= tail_next;
            end
            if (free_illegal) begin
                err <= 1'b1;
            end
            free_map <= map_next;
            count    <= count_next;
        end
    end

    a_count_matches_map: assert property (@(posedge CLK) disable iff (!RESET)
        count == (LOG_PHYS+1)'($countones(free_map)));

endmodule
